// File: rtl/coo_aggregation_controller.sv
// coo_aggregation_controller: GCN aggregation sequencer over a COO edge list into an internal output row buffer.
// Optional self-loop pass (buffer[i] += F·W[i]) is enabled by defining GCN_SELF_LOOP_EN.
module coo_aggregation_controller #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NUM_EDGES      = 6,
  parameter int FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int COO_ADDR_WIDTH = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  output logic                                           busy,
  output logic                                           done,
  output logic [COO_ADDR_WIDTH-1:0]                      coo_addr,
  input  logic [FEATURE_WIDTH-1:0]                       coo_src_in,
  input  logic [FEATURE_WIDTH-1:0]                       coo_dst_in,
  output logic [FEATURE_WIDTH-1:0]                       fm_wm_addr,
  input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     fm_wm_row_in,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     add_in1,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     add_in2,
  input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     add_sum,
  input  logic [FEATURE_WIDTH-1:0]                       out_rd_addr,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     out_row
);
  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] row_t;
  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH_EDGE, FETCH_ROW, ACC_DST, ACC_SRC,
`ifdef GCN_SELF_LOOP_EN
    SELF_FETCH, SELF_ACC,
`endif
    DONE
  } state_t;
  state_t state, nxt;
  logic [COO_ADDR_WIDTH-1:0] e;
  logic [FEATURE_WIDTH-1:0] src, dst, wr_idx;
  logic wr_en, last;
  row_t rows [FEATURE_ROWS];
`ifdef GCN_SELF_LOOP_EN
  logic [FEATURE_WIDTH-1:0] node;
`endif
  // out-of-range node indices read as zero and never write
  function automatic logic in_range(input logic [FEATURE_WIDTH-1:0] i);
    return 32'(i) < FEATURE_ROWS;
  endfunction
  function automatic row_t rd(input logic [FEATURE_WIDTH-1:0] i);
    return in_range(i) ? rows[i] : '0;
  endfunction
  assign last     = e == COO_ADDR_WIDTH'(NUM_EDGES - 1);
  assign coo_addr = e;
  assign busy     = state != IDLE && state != DONE;
  assign done     = state == DONE;
  assign out_row  = rd(out_rd_addr);
  always_comb begin
    nxt = state;
    fm_wm_addr = '0;
    add_in1 = '0;
    add_in2 = '0;
    wr_en = 1'b0;
    wr_idx = '0;
    case (state)
      IDLE:       nxt = start ? CLEAR : IDLE;
      CLEAR:      nxt = FETCH_EDGE;
      FETCH_EDGE: nxt = FETCH_ROW;
      FETCH_ROW: begin
        nxt = ACC_DST;
        fm_wm_addr = coo_src_in;
      end
      ACC_DST: begin
        nxt = ACC_SRC;
        fm_wm_addr = dst;
        add_in1 = rd(dst);
        add_in2 = fm_wm_row_in;
        wr_idx = dst;
        wr_en = in_range(dst);
      end
      ACC_SRC: begin
        add_in1 = rd(src);
        add_in2 = fm_wm_row_in;
        wr_idx = src;
        wr_en = in_range(src) && src != dst;
`ifdef GCN_SELF_LOOP_EN
        nxt = last ? SELF_FETCH : FETCH_EDGE;
`else
        nxt = last ? DONE : FETCH_EDGE;
`endif
      end
`ifdef GCN_SELF_LOOP_EN
      SELF_FETCH: begin
        nxt = SELF_ACC;
        fm_wm_addr = node;
      end
      SELF_ACC: begin
        nxt = (node == FEATURE_WIDTH'(FEATURE_ROWS - 1)) ? DONE : SELF_FETCH;
        add_in1 = rd(node);
        add_in2 = fm_wm_row_in;
        wr_idx = node;
        wr_en = 1'b1;
      end
`endif
      DONE:       nxt = start ? CLEAR : DONE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      e <= '0;
      src <= '0;
      dst <= '0;
`ifdef GCN_SELF_LOOP_EN
      node <= '0;
`endif
      for (int r = 0; r < FEATURE_ROWS; r++) rows[r] <= '0;
    end else begin
      state <= nxt;
      if (state == CLEAR) begin
        e <= '0;
`ifdef GCN_SELF_LOOP_EN
        node <= '0;
`endif
        for (int r = 0; r < FEATURE_ROWS; r++) rows[r] <= '0;
      end
      if (state == FETCH_ROW) begin
        src <= coo_src_in;
        dst <= coo_dst_in;
      end
      if (state == ACC_SRC && !last) e <= e + 1'b1;
`ifdef GCN_SELF_LOOP_EN
      if (state == SELF_ACC) node <= node + 1'b1;
`endif
      if (wr_en) rows[wr_idx] <= add_sum;
    end
  end
endmodule

// File: doc/coo_aggregation_controller.md
# coo_aggregation_controller

Sequencer for the GCN aggregation stage. It computes out = A·(F·W), where A is a symmetric adjacency held as a COO edge list and F·W is the already-computed feature-times-weight matrix. For each edge it fetches the COO pair, reads the two F·W rows and drives the external row adder twice. The adder results are written into an internal FEATURE_ROWS × WEIGHT_COLS output row buffer, which the downstream stage reads after `done`.

## Interface
- FEATURE_ROWS, 6, number of graph nodes / F·W rows
- WEIGHT_COLS, 3, elements per row
- DOT_PROD_WIDTH, 16, element width
- NUM_EDGES, 6, COO entries processed per run
- FEATURE_WIDTH, $clog2(FEATURE_ROWS), node index width
- COO_ADDR_WIDTH, $clog2(NUM_EDGES), COO memory address width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  high from run completion until the next accepted start
- coo_addr  out  COO_ADDR_WIDTH  COO memory read address
- coo_src_in  in  FEATURE_WIDTH  COO source node; valid 1 cycle after address
- coo_dst_in  in  FEATURE_WIDTH  COO destination node; valid 1 cycle after address
- fm_wm_addr  out  FEATURE_WIDTH  F·W row read address
- fm_wm_row_in  in  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  F·W row; valid 1 cycle after address
- add_in1  out  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  row adder operand 1 (buffer row)
- add_in2  out  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  row adder operand 2 (F·W row)
- add_sum  in  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  row adder combinational result
- out_rd_addr  in  FEATURE_WIDTH  output buffer read row
- out_row  out  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  combinational read of buffer[out_rd_addr]

## Operation
- States: IDLE, CLEAR, FETCH_EDGE, FETCH_ROW, ACC_DST, ACC_SRC, SELF_FETCH, SELF_ACC, DONE.
- IDLE: on start go to CLEAR.
- CLEAR: zero the whole buffer; edge counter e=0.
- FETCH_EDGE: coo_addr=e.
- FETCH_ROW: latch src/dst from COO data; fm_wm_addr=src.
- ACC_DST: add_in1=buffer[dst], add_in2=fm_wm_row_in; write buffer[dst]=add_sum; fm_wm_addr=dst.
- ACC_SRC: add_in1=buffer[src], add_in2=fm_wm_row_in; write buffer[src]=add_sum.
- After ACC_SRC: e==NUM_EDGES-1 ends the edge phase; otherwise e+1 and back to FETCH_EDGE.
- End of edge phase: go to DONE, or to SELF_FETCH when the Configuration macro is defined.
- Self-loop edge (src==dst): ACC_SRC performs no buffer write, so the contribution is added once.
- DONE: done=1, busy=0. start goes to CLEAR, dropping done on the same cycle busy rises.
- start in any non-IDLE/non-DONE state is ignored. It is not queued.
- Arithmetic is modulo 2^DOT_PROD_WIDTH; wrap-around is silent.
- Out-of-range node indices (≥FEATURE_ROWS) suppress the write for that step.
- Adder operands are 0 in every state other than ACC_DST, ACC_SRC and SELF_ACC.
- The buffer holds its contents from DONE until the next CLEAR and is readable at any time.

## Timing
- Reset values: state=IDLE, busy=0, done=0, coo_addr=0, fm_wm_addr=0, buffer all zero.
- add_in1/add_in2 are 0 during reset.
- Reset mid-run aborts immediately. The partial buffer is cleared and no done is produced.
- Memory read latency: 1 cycle, synchronous.
- Buffer write commits on the clock edge that ends an ACC state.
- Start sampled at edge T: CLEAR at T+1, first FETCH_EDGE at T+2.
- Each edge takes 4 cycles.
- done rises at T+2+4·NUM_EDGES (26 for the defaults).

## Configuration
- GCN_SELF_LOOP_EN defined: after the edge phase, for i=0..FEATURE_ROWS-1 the block runs SELF_FETCH then SELF_ACC.
  - SELF_FETCH: fm_wm_addr=i.
  - SELF_ACC: buffer[i] += fm_wm_row_in.
  - This adds 2·FEATURE_ROWS cycles, so done rises at T+2+4·NUM_EDGES+2·FEATURE_ROWS (38 for the defaults).
- GCN_SELF_LOOP_EN undefined: the SELF states do not exist and the edge phase goes directly to DONE.

## Test plan
F·W row i = {i+1, 10(i+1), 100(i+1)} in all scenarios.
- Reset, then idle for 10 cycles -> busy=0, done=0, every out_row = {0,0,0}.
- NUM_EDGES=1, edge (0,1), macro off -> done at T+6; out_row[0]={2,20,200}, out_row[1]={1,10,100}, rows 2-5 zero.
- 6 edges (0,1)(1,2)(2,3)(3,4)(4,5)(5,0), macro off -> done at T+26; out_row[0]={8,80,800}, out_row[3]={8,80,800}.
- Self-loop edge (2,2) with NUM_EDGES=1 -> out_row[2]={3,30,300}, not doubled. With GCN_SELF_LOOP_EN -> out_row[2]={6,60,600}, row 0={1,10,100}.
- start pulsed at T+5 during a run -> ignored, and the done time is unchanged. rst_n low at T+10 -> state IDLE, buffer zero, no done.
- Wrap test: F·W row 1 = {0xFFFF,1,0}, edge (0,1) twice -> out_row[0]={0xFFFE,2,0}. A second start after DONE re-clears the buffer, and the results repeat identically.
